// File: rtl/read_data_returner_if.sv
// Processor load port and RAM read port of the read-back path.
// slave is the read_data_returner's view; master is the requester/RAM side.
interface read_data_returner_if #(
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [15:0]       rd_add;
  logic              rd_busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  logic              ram_rd_en;
  logic [15:0]       ram_add;
  logic [DATA_W-1:0] ram_data;
  logic              ram_valid;

  modport slave (
    input  rd_req, rd_add, ram_data, ram_valid,
    output rd_busy, rd_data, rd_valid, rd_err, ram_rd_en, ram_add
  );

  modport master (
    output rd_req, rd_add, ram_data, ram_valid,
    input  rd_busy, rd_data, rd_valid, rd_err, ram_rd_en, ram_add
  );
endinterface

// File: rtl/read_data_returner.sv
// Returns read data to the processor: register-file words in one cycle,
// RAM words after a strobed request, with a bounded wait and an error response.
module read_data_returner #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 17,
  parameter int RAM_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data,
  read_data_returner_if.slave        bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] RAM_WAIT = 1'b1;

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [15:0] REG_LIMIT  = 16'(NUM_REGS);
  localparam logic [7:0]  COUNT_LAST = 8'(RAM_TIMEOUT - 1);

  logic [0:0]        state;
  logic [7:0]        count;
  logic              is_reg;
  logic [DATA_W-1:0] reg_word;

  assign is_reg = (bus.rd_add < REG_LIMIT);

  // Indices beyond the register file select zero; is_reg keeps them unused.
  always_comb begin
    reg_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_add[IDX_W-1:0] == IDX_W'(i)) begin
        reg_word = reg_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.ram_rd_en <= 1'b0;
      bus.ram_add   <= '0;
    end else begin
      // Strobes are single-cycle unless a rule below re-asserts them.
      bus.rd_valid  <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.ram_rd_en <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            if (is_reg) begin
              bus.rd_data  <= reg_word;
              bus.rd_valid <= 1'b1;
            end else begin
              bus.ram_rd_en <= 1'b1;
              bus.ram_add   <= bus.rd_add;
              count         <= '0;
              state         <= RAM_WAIT;
            end
          end
        end

        RAM_WAIT: begin
          // Data beats timeout when both land on the same edge.
          if (bus.ram_valid) begin
            bus.rd_data  <= bus.ram_data;
            bus.rd_valid <= 1'b1;
            count        <= '0;
            state        <= IDLE;
          end else if (count == COUNT_LAST) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b1;
            bus.rd_err   <= 1'b1;
            count        <= '0;
            state        <= IDLE;
          end else begin
            count <= count + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_busy = (state == RAM_WAIT);

endmodule

// File: tb/tb_read_data_returner.sv
// Directed bench for read_data_returner: transaction-level model checked every
// cycle, plus literal expectations at the points of interest.
module tb_read_data_returner;

  localparam int DATA_W      = 16;
  localparam int NUM_REGS    = 17;
  localparam int RAM_TIMEOUT = 4;

  logic                       clk   = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] reg_data;

  read_data_returner_if #(.DATA_W(DATA_W)) bus ();

  read_data_returner #(
    .DATA_W      (DATA_W),
    .NUM_REGS    (NUM_REGS),
    .RAM_TIMEOUT (RAM_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_data (reg_data),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a request is either answered from the register file at once, or
  // becomes an outstanding RAM read that ends on data or after RAM_TIMEOUT
  // full wait cycles.
  logic              m_valid   = 1'b0;
  logic              m_err     = 1'b0;
  logic              m_rd_en   = 1'b0;
  logic [DATA_W-1:0] m_data    = '0;
  logic [15:0]       m_ram_add = '0;
  bit                m_pending = 1'b0;
  int                m_waited  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_err = 1'b0; m_rd_en = 1'b0;
      m_data = '0; m_ram_add = '0; m_pending = 1'b0; m_waited = 0;
    end else begin
      m_valid = 1'b0; m_err = 1'b0; m_rd_en = 1'b0;
      if (m_pending) begin
        if (bus.ram_valid) begin
          m_data = bus.ram_data; m_valid = 1'b1; m_pending = 1'b0;
        end else if (m_waited + 1 == RAM_TIMEOUT) begin
          m_data = '0; m_valid = 1'b1; m_err = 1'b1; m_pending = 1'b0;
        end else begin
          m_waited++;
        end
      end else if (bus.rd_req) begin
        if (int'(bus.rd_add) < NUM_REGS) begin
          m_data  = reg_data[int'(bus.rd_add)*DATA_W +: DATA_W];
          m_valid = 1'b1;
        end else begin
          m_pending = 1'b1; m_waited = 0; m_rd_en = 1'b1; m_ram_add = bus.rd_add;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_valid",  32'(bus.rd_valid),  32'(m_valid));
      check("rd_err",    32'(bus.rd_err),    32'(m_err));
      check("rd_data",   32'(bus.rd_data),   32'(m_data));
      check("rd_busy",   32'(bus.rd_busy),   32'(m_pending));
      check("ram_rd_en", 32'(bus.ram_rd_en), 32'(m_rd_en));
      check("ram_add",   32'(bus.ram_add),   32'(m_ram_add));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input string name, input logic v, input logic e, input logic [15:0] d);
    check({name, ".valid"}, 32'(bus.rd_valid), 32'(v));
    check({name, ".err"},   32'(bus.rd_err),   32'(e));
    if (v) check({name, ".data"}, 32'(bus.rd_data), 32'(d));
  endtask

  task automatic expect_all_zero(input string name);
    check({name, ".rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({name, ".rd_err"},    32'(bus.rd_err),    32'd0);
    check({name, ".rd_data"},   32'(bus.rd_data),   32'd0);
    check({name, ".rd_busy"},   32'(bus.rd_busy),   32'd0);
    check({name, ".ram_rd_en"}, 32'(bus.ram_rd_en), 32'd0);
    check({name, ".ram_add"},   32'(bus.ram_add),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < NUM_REGS; i++) reg_data[i*DATA_W +: DATA_W] = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1'($urandom); bus.rd_add = 16'($urandom);
      bus.ram_valid = 1'($urandom); bus.ram_data = 16'($urandom);
      tick();
    end
    expect_all_zero("reset_hold");
    bus.rd_req = 1'b0; bus.rd_add = '0; bus.ram_valid = 1'b0; bus.ram_data = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_data[i*DATA_W +: DATA_W] = 16'(16'h1000 + i);
    rst_n = 1'b1;
    tick();
    expect_all_zero("after_release");

    // Back-to-back register reads, including the top register
    bus.rd_req = 1'b1; bus.rd_add = 16'd0;  tick(); expect_resp("reg0",  1'b1, 1'b0, 16'h1000);
    check("reg0.ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
    bus.rd_add = 16'd5;  tick(); expect_resp("reg5",  1'b1, 1'b0, 16'h1005);
    bus.rd_add = 16'd16; tick(); expect_resp("reg16", 1'b1, 1'b0, 16'h1010);
    bus.rd_req = 1'b0;   tick(); expect_resp("reg_idle", 1'b0, 1'b0, 16'h0);
    check("reg_hold.data", 32'(bus.rd_data), 32'h1010);

    // RAM read at the first RAM address, with an ignored request while busy
    bus.rd_req = 1'b1; bus.rd_add = 16'h0011; tick();
    check("ram.rd_en", 32'(bus.ram_rd_en), 32'd1);
    check("ram.add",   32'(bus.ram_add),   32'h0011);
    check("ram.busy",  32'(bus.rd_busy),   32'd1);
    bus.rd_add = 16'd3; tick();
    check("ram.rd_en_drop", 32'(bus.ram_rd_en), 32'd0);
    expect_resp("ram.ignored_req", 1'b0, 1'b0, 16'h0);
    bus.rd_req = 1'b0; tick();
    bus.ram_valid = 1'b1; bus.ram_data = 16'hBEEF; tick();
    expect_resp("ram.data", 1'b1, 1'b0, 16'hBEEF);
    check("ram.busy_done", 32'(bus.rd_busy), 32'd0);
    bus.ram_valid = 1'b0; tick();
    expect_resp("ram.no_extra", 1'b0, 1'b0, 16'h0);

    // Timeout on the top address, then a stray RAM response
    bus.rd_req = 1'b1; bus.rd_add = 16'hFFFF; tick();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_resp("to.waiting", 1'b0, 1'b0, 16'h0);
    end
    tick();
    expect_resp("to.err", 1'b1, 1'b1, 16'h0000);
    bus.ram_valid = 1'b1; bus.ram_data = 16'h1234; tick();
    expect_resp("to.stray", 1'b0, 1'b0, 16'h0);
    bus.ram_valid = 1'b0;

    // RAM data on the timeout edge wins; new request in the response cycle
    bus.rd_req = 1'b1; bus.rd_add = 16'hFFFF; tick();
    bus.rd_req = 1'b0;
    tick(); tick(); tick();
    bus.ram_valid = 1'b1; bus.ram_data = 16'hCAFE; tick();
    expect_resp("race.data", 1'b1, 1'b0, 16'hCAFE);
    bus.ram_valid = 1'b0;
    bus.rd_req = 1'b1; bus.rd_add = 16'd7; tick();
    expect_resp("race.next", 1'b1, 1'b0, 16'h1007);
    bus.rd_req = 1'b0; tick();

    // Asynchronous reset mid-cycle while a register response is visible
    bus.rd_req = 1'b1; bus.rd_add = 16'd9; tick();
    expect_resp("async.pre", 1'b1, 1'b0, 16'h1009);
    bus.rd_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 expect_all_zero("async_reset");
    #1 rst_n = 1'b1;

    // Reset during RAM wait abandons the request
    tick();
    bus.rd_req = 1'b1; bus.rd_add = 16'h0100; tick();
    bus.rd_req = 1'b0; tick();
    check("midwait.busy", 32'(bus.rd_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("midwait.busy_cleared", 32'(bus.rd_busy), 32'd0);
    #1 rst_n = 1'b1;
    bus.ram_valid = 1'b1; bus.ram_data = 16'h5555; tick();
    expect_resp("midwait.stray", 1'b0, 1'b0, 16'h0);
    check("midwait.idle", 32'(bus.rd_busy), 32'd0);
    bus.ram_valid = 1'b0;
    bus.rd_req = 1'b1; bus.rd_add = 16'd2; tick();
    expect_resp("midwait.reg2", 1'b1, 1'b0, 16'h1002);
    bus.rd_req = 1'b0; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
